// File: rtl/acc_pkg.sv
// Shared types and constants for the accelerator input-stream feeder.
// Path-select codes, feeder state encoding and default widths.
// No logic; imported by the feeder and its prefetch buffer.
package acc_pkg;

    localparam int DWIDTH_DEF     = 64;
    localparam int CTRL_WIDTH_DEF = DWIDTH_DEF / 8;
    localparam int AWIDTH_DEF     = 10;
    localparam int HDR_WORDS_DEF  = 5;

    localparam logic [1:0] PATH_ALU = 2'b00;
    localparam logic [1:0] PATH_ENC = 2'b01;
    localparam logic [1:0] PATH_DEC = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } feed_state_t;

endpackage

// File: rtl/acc_feed_skid.sv
// 2-entry show-ahead FIFO holding {ctrl,data} words returned by the packet SRAM.
// Latency: a push is visible on head the cycle after it is written.
// Backpressure: none internally; the caller keeps pushes within the 2-entry capacity.
module acc_feed_skid
    import acc_pkg::*;
#(
    parameter int WIDTH = DWIDTH_DEF + CTRL_WIDTH_DEF
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/acc_stream_feeder.sv
// Reads one packet from the packet SRAM and streams it out as data/ctrl words with side-band.
// Latency: first word valid 2 cycles after start is accepted; then 1 word/cycle.
// Backpressure: out_rdy low stalls the stream; reads are throttled to the 2-entry prefetch buffer.
module acc_stream_feeder
    import acc_pkg::*;
#(
    parameter int DWIDTH     = DWIDTH_DEF,
    parameter int CTRL_WIDTH = DWIDTH / 8,
    parameter int AWIDTH     = AWIDTH_DEF,
    parameter int HDR_WORDS  = HDR_WORDS_DEF
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic [AWIDTH-1:0]            i_base_addr,
    input  logic [15:0]                  i_num_words,
    input  logic [1:0]                   i_path_sel,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_rd_en,
    output logic [AWIDTH-1:0]            o_rd_addr,
    input  logic [DWIDTH+CTRL_WIDTH-1:0] i_rd_data,
    output logic [DWIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]        out_ctrl,
    output logic                         out_wr,
    input  logic                         out_rdy,
    output logic [15:0]                  data_count,
    output logic                         inside_payload,
    output logic [1:0]                   path_sel
);

    feed_state_t state, state_nxt;

    logic [AWIDTH-1:0]            base_q;
    logic [15:0]                  len_q;
    logic [15:0]                  rd_idx;
    logic [15:0]                  xfer_cnt;
    logic [1:0]                   path_q;
    logic                         inflight;
    logic [1:0]                   fifo_cnt;
    logic [DWIDTH+CTRL_WIDTH-1:0] head;
    logic                         pop;
    logic                         rd_en;
    logic                         start_acc;
    logic                         last_rd;
    logic                         last_xfer;
    logic [2:0]                   occ;

    assign out_wr    = (fifo_cnt != 2'd0);
    assign pop       = out_wr & out_rdy;
    // Words already committed to the buffer once this cycle's pop leaves.
    assign occ       = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign last_rd   = (rd_idx == len_q - 16'd1);
    assign last_xfer = pop && (xfer_cnt == len_q - 16'd1);

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        start_acc = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    start_acc = 1'b1;
                    state_nxt = (i_num_words == 16'd0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (occ < 3'd2) begin
                    rd_en = 1'b1;
                    if (last_rd) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (last_xfer) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            base_q   <= '0;
            len_q    <= 16'd0;
            rd_idx   <= 16'd0;
            xfer_cnt <= 16'd0;
            path_q   <= PATH_ALU;
            inflight <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= rd_en;
            if (start_acc) begin
                base_q   <= i_base_addr;
                len_q    <= i_num_words;
                path_q   <= i_path_sel;
                rd_idx   <= 16'd0;
                xfer_cnt <= 16'd0;
            end else begin
                if (rd_en) begin
                    rd_idx <= rd_idx + 16'd1;
                end
                if (pop) begin
                    xfer_cnt <= xfer_cnt + 16'd1;
                end
            end
        end
    end

    acc_feed_skid #(
        .WIDTH(DWIDTH + CTRL_WIDTH)
    ) u_skid (
        .i_clock  (i_clock),
        .i_reset  (i_reset),
        .push     (inflight),
        .push_dat (i_rd_data),
        .pop      (pop),
        .count    (fifo_cnt),
        .head     (head)
    );

    assign o_busy         = (state != ST_IDLE);
    assign o_done         = (state == ST_DONE);
    assign o_rd_en        = rd_en;
    assign o_rd_addr      = base_q + rd_idx[AWIDTH-1:0];
    assign out_data       = head[DWIDTH-1:0];
    assign out_ctrl       = head[DWIDTH +: CTRL_WIDTH];
    assign data_count     = xfer_cnt;
    assign inside_payload = (xfer_cnt >= 16'(HDR_WORDS)) && out_wr;
    assign path_sel       = path_q;

endmodule

// File: tb/tb_acc_stream_feeder.sv
// Scoreboard bench for acc_stream_feeder: SRAM model, expected-word and read-address queues.
module tb_acc_stream_feeder;
    import acc_pkg::*;

    typedef struct {
        logic [63:0] d;
        logic [7:0]  c;
        logic [15:0] idx;
    } exp_t;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_start;
    logic [9:0]  i_base_addr;
    logic [15:0] i_num_words;
    logic [1:0]  i_path_sel;
    logic        o_busy, o_done, o_rd_en;
    logic [9:0]  o_rd_addr;
    logic [71:0] i_rd_data = '0;
    logic [63:0] out_data;
    logic [7:0]  out_ctrl;
    logic        out_wr;
    logic        out_rdy;
    logic [15:0] data_count;
    logic        inside_payload;
    logic [1:0]  path_sel;

    int n_tests = 0;
    int n_fail  = 0;
    int n_rd = 0, n_xf = 0, cyc = 0, last_xfer_cyc = 0;
    logic [1:0] exp_path = PATH_ALU;
    exp_t       exp_q[$];
    logic [9:0] exp_addr[$];

    logic bp_mode = 1'b0;
    int   bp_k = 0;
    bit   bp_pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    acc_stream_feeder dut (
        .i_clock        (i_clock),
        .i_reset        (i_reset),
        .i_start        (i_start),
        .i_base_addr    (i_base_addr),
        .i_num_words    (i_num_words),
        .i_path_sel     (i_path_sel),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_rd_en        (o_rd_en),
        .o_rd_addr      (o_rd_addr),
        .i_rd_data      (i_rd_data),
        .out_data       (out_data),
        .out_ctrl       (out_ctrl),
        .out_wr         (out_wr),
        .out_rdy        (out_rdy),
        .data_count     (data_count),
        .inside_payload (inside_payload),
        .path_sel       (path_sel)
    );

    always #5 i_clock = ~i_clock;

    function automatic logic [71:0] sram_word(input logic [9:0] a);
        return {a[7:0] ^ 8'hA5, 32'hC0DE_0000 | {22'b0, a}, 22'h0, a};
    endfunction

    // Packet SRAM: one-cycle read latency.
    always @(posedge i_clock) begin
        if (o_rd_en) i_rd_data <= sram_word(o_rd_addr);
    end

    always @(posedge i_clock) begin
        #1;
        if (bp_mode) begin
            out_rdy = bp_pat[bp_k];
            bp_k = (bp_k + 1) % 6;
        end
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor: checks every read address and every valid word against the queues.
    always @(negedge i_clock) begin
        cyc++;
        if (!i_reset) begin
            if (o_rd_en) begin
                check("rd_avail", exp_addr.size() > 0, 1);
                check("rd_outstanding", (n_rd - n_xf + 1 - int'(out_wr && out_rdy)) <= 2, 1);
                if (exp_addr.size() > 0) check("rd_addr", o_rd_addr, exp_addr.pop_front());
                n_rd++;
            end
            if (out_wr) begin
                check("wr_avail", exp_q.size() > 0, 1);
                check("path_sel", path_sel, exp_path);
                if (exp_q.size() > 0) begin
                    check("out_data", out_data, exp_q[0].d);
                    check("out_ctrl", out_ctrl, exp_q[0].c);
                    check("data_count", data_count, exp_q[0].idx);
                    check("inside_payload", inside_payload, exp_q[0].idx >= 16'd5);
                    if (out_rdy) begin
                        void'(exp_q.pop_front());
                        n_xf++;
                        last_xfer_cyc = cyc;
                    end
                end
            end
        end
    end

    task automatic start_pkt(input logic [9:0] base, input int len, input logic [1:0] path);
        logic [9:0]  a;
        logic [71:0] w;
        n_rd = 0;
        n_xf = 0;
        exp_path = path;
        for (int i = 0; i < len; i++) begin
            a = base + 10'(i);
            w = sram_word(a);
            exp_addr.push_back(a);
            exp_q.push_back('{d: w[63:0], c: w[71:64], idx: 16'(i)});
        end
        i_start     = 1'b1;
        i_base_addr = base;
        i_num_words = 16'(len);
        i_path_sel  = path;
        @(posedge i_clock);
        #1 i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int len, output int waited);
        bit seen;
        seen = 0;
        waited = 0;
        for (int i = 1; i <= 300 && !seen; i++) begin
            @(negedge i_clock);
            #1;
            if (o_done) begin
                seen = 1;
                waited = i;
            end
        end
        check({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            check({tag, "_xfers"}, n_xf, len);
            check({tag, "_reads"}, n_rd, len);
            check({tag, "_exp_left"}, exp_q.size() + exp_addr.size(), 0);
            check({tag, "_done_gap"}, cyc - last_xfer_cyc, 1);
            @(negedge i_clock);
            #1 check({tag, "_idle_after"}, {o_busy, o_done}, 2'b00);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctl"}, {o_busy, o_done, o_rd_en, out_wr, inside_payload}, 5'b0);
        check({tag, "_addr"}, o_rd_addr, 10'h000);
        check({tag, "_data"}, {out_ctrl, out_data}, 72'h0);
        check({tag, "_count"}, data_count, 16'd0);
        check({tag, "_path"}, path_sel, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int   waited;
        bit   done_seen;
        i_reset = 1'b1;
        i_start = 1'b0;
        i_base_addr = '0;
        i_num_words = '0;
        i_path_sel  = '0;
        out_rdy     = 1'b1;
        #3 check_reset_outputs("por");
        @(posedge i_clock);
        @(posedge i_clock);
        #1 i_reset = 1'b0;
        @(posedge i_clock);
        #1;

        // Basic packet: first word valid two cycles after start acceptance.
        start_pkt(10'h010, 6, PATH_ENC);
        @(negedge i_clock);
        #1 check("basic_e0", {o_busy, o_rd_en, out_wr}, 3'b110);
        check("basic_first_addr", o_rd_addr, 10'h010);
        @(negedge i_clock);
        #1 check("basic_e1", {o_rd_en, out_wr}, 2'b10);
        @(negedge i_clock);
        #1 check("basic_e2", {o_rd_en, out_wr}, 2'b11);
        wait_done("basic", 6, waited);
        check("basic_done_cycle", waited, 6);

        // Backpressure with ready pattern 1,0,0,1,0,1 repeating.
        bp_k = 0;
        bp_mode = 1'b1;
        start_pkt(10'h120, 8, PATH_DEC);
        wait_done("bp", 8, waited);
        bp_mode = 1'b0;
        out_rdy = 1'b1;
        @(posedge i_clock);
        #1;

        // Zero length: busy and done for a single cycle, no reads or words.
        start_pkt(10'h055, 0, PATH_ALU);
        @(negedge i_clock);
        #1 check("zero_e0", {o_busy, o_done, o_rd_en, out_wr}, 4'b1100);
        @(negedge i_clock);
        #1 check("zero_e1", {o_busy, o_done, o_rd_en, out_wr}, 4'b0000);
        @(posedge i_clock);
        #1;

        // Address wrap at the top of the SRAM.
        start_pkt(10'h3FE, 4, PATH_ALU);
        wait_done("wrap", 4, waited);
        @(posedge i_clock);
        #1;

        // Second start while busy must be ignored.
        start_pkt(10'h100, 10, PATH_DEC);
        repeat (3) @(posedge i_clock);
        #1;
        i_start = 1'b1;
        i_path_sel = PATH_ENC;
        i_num_words = 16'd3;
        i_base_addr = 10'h200;
        @(posedge i_clock);
        #1 i_start = 1'b0;
        wait_done("busy_start", 10, waited);
        repeat (3) @(negedge i_clock);
        #1 check("busy_start_quiet", {o_busy, o_rd_en, out_wr}, 3'b000);
        @(posedge i_clock);
        #1;

        // Asynchronous reset after three transfers.
        start_pkt(10'h050, 10, PATH_ENC);
        for (int i = 0; i < 100 && n_xf < 3; i++) begin
            @(negedge i_clock);
            #1;
        end
        check("rst_reached_3", n_xf, 3);
        @(posedge i_clock);
        #3 i_reset = 1'b1;
        #1 check_reset_outputs("midrst");
        exp_q.delete();
        exp_addr.delete();
        n_rd = 0;
        n_xf = 0;
        @(posedge i_clock);
        @(posedge i_clock);
        #1 i_reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clock);
            #1 if (o_done) done_seen = 1;
        end
        check("midrst_no_done", done_seen, 0);
        @(posedge i_clock);
        #1;
        start_pkt(10'h060, 2, PATH_DEC);
        wait_done("post_rst", 2, waited);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/acc_stream_feeder.md
Name: acc_stream_feeder

Overview:
- Source end of the accelerator's input stream.
- Reads one packet's words (data plus ctrl) from the packet SRAM and drives them as a 64-bit data/ctrl stream with a valid/ready handshake.
- Generates the per-word side-band the accelerator consumes: word index, header/payload flag and path select.
- A 2-entry prefetch buffer hides the 1-cycle SRAM read latency, so the block sustains 1 word/cycle under arbitrary backpressure.

Parameters:
DWIDTH, 64, stream data width
CTRL_WIDTH, DWIDTH/8, ctrl width (one bit per data byte)
AWIDTH, 10, SRAM word-address width
HDR_WORDS, 5, words per packet treated as header; data_count >= HDR_WORDS means payload

Ports:
i_clock  in  1  clock, rising edge
i_reset  in  1  reset, asynchronous, active-high
i_start  in  1  packet request; sampled only in IDLE
i_base_addr  in  AWIDTH  SRAM address of word 0
i_num_words  in  16  packet length in words
i_path_sel  in  2  path for this packet (00 ALU, 01 encrypt, 10 decrypt)
o_busy  out  1  packet in progress
o_done  out  1  1-cycle pulse after last word transfers
o_rd_en  out  1  SRAM read strobe
o_rd_addr  out  AWIDTH  SRAM read address
i_rd_data  in  DWIDTH+CTRL_WIDTH  {ctrl,data}; valid the cycle after o_rd_en
out_data  out  DWIDTH  stream data
out_ctrl  out  CTRL_WIDTH  stream ctrl, passed unmodified from SRAM
out_wr  out  1  word valid
out_rdy  in  1  sink ready; transfer occurs on out_wr && out_rdy
data_count  out  16  index of the word currently on out_data
inside_payload  out  1  (data_count >= HDR_WORDS) && out_wr
path_sel  out  2  latched i_path_sel, held for the whole packet

Behaviour:
- Reset (async, active-high) values:
  - State IDLE; buffer empty; read and transfer counters 0.
  - o_busy=0, o_done=0, o_rd_en=0, o_rd_addr=0, out_wr=0, out_data=0, out_ctrl=0, data_count=0, inside_payload=0, path_sel=00.
  - Reset mid-packet abandons the packet: no o_done is produced, and the in-flight SRAM read is discarded.
- States:
  - IDLE: i_start=1 latches base, length and path_sel.
    - Length 0 -> DONE.
    - Otherwise -> READ.
  - READ: issues reads.
    - -> DRAIN the cycle after the read of word num_words-1 is issued.
  - DRAIN: no reads.
    - -> DONE on the cycle the last word transfers (transfer count reaches num_words).
  - DONE: o_done=1 for exactly one cycle -> IDLE.
  - o_busy=1 in READ, DRAIN and DONE.
  - i_start is ignored in every state except IDLE.
- Read issue:
  - o_rd_en=1 in READ when (buffer occupancy + reads in flight − pop this cycle) < 2.
  - o_rd_addr = base + read index, modulo 2^AWIDTH; address wrap is legal.
- Latency and throughput:
  - i_start sampled at edge E0 -> o_rd_en high after E0 -> data written to buffer at E2 -> out_wr high after E2.
  - First word is therefore valid 2 cycles after start acceptance.
  - With out_rdy held at 1, one word transfers every cycle.
- Stream rules:
  - out_wr=1 whenever the buffer is non-empty; out_data and out_ctrl show the buffer head.
  - While out_wr=1 && out_rdy=0: out_data, out_ctrl, data_count and inside_payload hold stable.
  - data_count increments by 1 per transfer and clears to 0 when a new packet starts.
- Buffer boundaries:
  - A push and a pop in the same cycle keep occupancy unchanged.
  - Push to a full buffer cannot occur: the read-issue rule guarantees this, and the bench asserts it.
  - A pop from an empty buffer is impossible, since out_wr=0 when empty.
- Reads stop at exactly num_words; the block never over-fetches.

Decomposition:
- Shared package acc_pkg:
  - path-select constants PATH_ALU=2'b00, PATH_ENC=2'b01, PATH_DEC=2'b10.
  - feeder state encoding.
  - DWIDTH/CTRL_WIDTH defaults.
- One sub-module, acc_feed_skid:
  - 2-entry show-ahead FIFO of {ctrl,data}.
  - Ports: push, pop, count, head.
  - Reset asynchronous, active-high.

Test Plan:
- Basic packet: base=0x010, len=6, path=01, out_rdy=1. Expect:
  - reads 0x010..0x015 on consecutive cycles.
  - out_wr high 6 consecutive cycles, starting 2 cycles after start.
  - data_count 0..5 and inside_payload 0,0,0,0,0,1.
  - path_sel=01 throughout; o_done one cycle after the 6th transfer.
- Backpressure: len=8, out_rdy toggled 1,0,0,1,0,1,... Expect:
  - all 8 words delivered in order with no duplicates or drops.
  - outputs stable while stalled; never more than 2 reads outstanding beyond transfers.
- Zero length: i_start with len=0. Expect no o_rd_en, no out_wr, o_busy high 1 cycle and o_done pulse in that cycle.
- Address wrap: AWIDTH=10, base=0x3FE, len=4. Expect o_rd_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
- Start while busy: second i_start during a len=10 packet with different path_sel. Expect it ignored, path_sel unchanged and exactly 10 words transferred.
- Reset mid-packet: assert i_reset asynchronously after 3 transfers of a len=10 packet. Expect:
  - all outputs at reset values immediately; no o_done.
  - a following len=2 packet is delivered correctly with data_count starting at 0.
